// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: grant owner encodings
// and the default DMA burst length.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_CPU = 2'd0,
    OWN_VID = 2'd1,
    OWN_DMA = 2'd2
  } owner_e;

  localparam int DMA_BURST_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port between the CPU, video fetch and DMA.
// The CPU is stalled via RDY and fed replayed read data while it does not own the bus.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DMA_BURST = DMA_BURST_DEF,
  parameter int AW        = 16
) (
  input  logic          clk,
  input  logic          RST,
  input  logic [AW-1:0] cpu_ad,
  input  logic [7:0]    cpu_do,
  input  logic          cpu_we,
  output logic          cpu_rdy,
  output logic [7:0]    cpu_di,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_ad,
  output logic          vid_ack,
  output logic          vid_valid,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_ad,
  input  logic [7:0]    dma_do,
  input  logic          dma_we,
  output logic          dma_ack,
  output logic          dma_valid,
  output logic [7:0]    rd_data,
  output logic [AW-1:0] mem_ad,
  output logic [7:0]    mem_do,
  output logic          mem_we,
  input  logic [7:0]    mem_di,
  output logic [1:0]    owner
);

  localparam logic [3:0] BURST_MAX = 4'(DMA_BURST);

  owner_e     w_owner;
  owner_e     r_tag;
  logic [7:0] r_hold;
  logic [3:0] r_burst_cnt;
  logic       r_dma_we_q;
  logic       w_burst_full;

  assign w_burst_full = (r_burst_cnt == BURST_MAX);

  // Address-phase grant: VID > DMA > CPU, DMA refused once its burst is spent.
  always_comb begin
    w_owner = OWN_CPU;
    if (RST)                          w_owner = OWN_CPU;
    else if (vid_req)                 w_owner = OWN_VID;
    else if (dma_req && !w_burst_full) w_owner = OWN_DMA;
  end

  always_comb begin
    mem_ad = cpu_ad;
    mem_do = cpu_do;
    mem_we = cpu_we;
    unique case (w_owner)
      OWN_VID: begin
        mem_ad = vid_ad;
        mem_do = 8'h00;
        mem_we = 1'b0;
      end
      OWN_DMA: begin
        mem_ad = dma_ad;
        mem_do = dma_do;
        mem_we = dma_we;
      end
      default: ;
    endcase
  end

  assign owner   = w_owner;
  assign cpu_rdy = (w_owner == OWN_CPU);
  assign vid_ack = (w_owner == OWN_VID);
  assign dma_ack = (w_owner == OWN_DMA);

  always_ff @(posedge clk) begin
    if (RST) begin
      r_tag       <= OWN_CPU;
      r_hold      <= 8'h00;
      r_burst_cnt <= 4'd0;
      r_dma_we_q  <= 1'b0;
    end else begin
      r_tag      <= w_owner;
      r_dma_we_q <= (w_owner == OWN_DMA) && dma_we;
      if (r_tag == OWN_CPU) r_hold <= mem_di;
      if (w_owner == OWN_CPU)
        r_burst_cnt <= 4'd0;
      else if (w_owner == OWN_DMA && !w_burst_full)
        r_burst_cnt <= r_burst_cnt + 4'd1;
    end
  end

  // Data phase: a stalled core keeps seeing its last read byte.
  assign rd_data   = mem_di;
  assign cpu_di    = (r_tag == OWN_CPU) ? mem_di : r_hold;
  assign vid_valid = (r_tag == OWN_VID);
  // A reset arriving in the data phase drops the read the DMA engine was owed.
  assign dma_valid = (r_tag == OWN_DMA) && !r_dma_we_q && !RST;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: idle CPU, video steal, DMA burst limit,
// contention, DMA write and reset in the middle of a DMA read.
module tb_mem_arbiter;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          RST;
  logic [AW-1:0] cpu_ad;
  logic [7:0]    cpu_do;
  logic          cpu_we;
  logic          cpu_rdy;
  logic [7:0]    cpu_di;
  logic          vid_req;
  logic [AW-1:0] vid_ad;
  logic          vid_ack;
  logic          vid_valid;
  logic          dma_req;
  logic [AW-1:0] dma_ad;
  logic [7:0]    dma_do;
  logic          dma_we;
  logic          dma_ack;
  logic          dma_valid;
  logic [7:0]    rd_data;
  logic [AW-1:0] mem_ad;
  logic [7:0]    mem_do;
  logic          mem_we;
  logic [7:0]    mem_di;
  logic [1:0]    owner;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.DMA_BURST(4), .AW(AW)) dut (
    .clk(clk), .RST(RST),
    .cpu_ad(cpu_ad), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_rdy(cpu_rdy), .cpu_di(cpu_di),
    .vid_req(vid_req), .vid_ad(vid_ad), .vid_ack(vid_ack), .vid_valid(vid_valid),
    .dma_req(dma_req), .dma_ad(dma_ad), .dma_do(dma_do), .dma_we(dma_we),
    .dma_ack(dma_ack), .dma_valid(dma_valid),
    .rd_data(rd_data),
    .mem_ad(mem_ad), .mem_do(mem_do), .mem_we(mem_we), .mem_di(mem_di),
    .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cpu_cycles;
    logic [3:0] burst_m;
    logic prev_dma;
    logic [1:0] exp_own;

    RST = 1'b1; cpu_ad = 16'h1234; cpu_do = 8'h00; cpu_we = 1'b1;
    vid_req = 1'b1; vid_ad = 16'h0000; dma_req = 1'b1; dma_ad = 16'h0000;
    dma_do = 8'h00; dma_we = 1'b0; mem_di = 8'h00;
    #1;
    chk("rst_owner",   32'(owner),   32'd0);
    chk("rst_rdy",     32'(cpu_rdy), 32'd1);
    chk("rst_vid_ack", 32'(vid_ack), 32'd0);
    chk("rst_dma_ack", 32'(dma_ack), 32'd0);
    chk("rst_mem_we",  32'(mem_we),  32'd1);
    tick();
    chk("rst_burst", 32'(dut.r_burst_cnt), 32'd0);
    chk("rst_cpu_di", 32'(cpu_di), 32'd0);

    // Idle: CPU reads 1234, memory answers A5.
    RST = 1'b0; vid_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0;
    #1;
    chk("idle_owner",  32'(owner),   32'd0);
    chk("idle_rdy",    32'(cpu_rdy), 32'd1);
    chk("idle_mem_ad", 32'(mem_ad),  32'h1234);
    tick();
    mem_di = 8'hA5;
    // Video steals this cycle; CPU tries a write that must not reach memory.
    vid_req = 1'b1; vid_ad = 16'h8000; cpu_we = 1'b1; cpu_do = 8'h77;
    #1;
    chk("idle_cpu_di",  32'(cpu_di),  32'hA5);
    chk("vid_rdy",      32'(cpu_rdy), 32'd0);
    chk("vid_ack",      32'(vid_ack), 32'd1);
    chk("vid_owner",    32'(owner),   32'd1);
    chk("vid_mem_ad",   32'(mem_ad),  32'h8000);
    chk("vid_mem_we",   32'(mem_we),  32'd0);
    tick();
    vid_req = 1'b0; cpu_we = 1'b0; mem_di = 8'h3C;
    #1;
    chk("vid_valid",   32'(vid_valid), 32'd1);
    chk("vid_rd_data", 32'(rd_data),   32'h3C);
    chk("vid_replay",  32'(cpu_di),    32'hA5);
    chk("vid_rdy_back",32'(cpu_rdy),   32'd1);
    tick();
    mem_di = 8'h11;
    #1;
    chk("post_vid_di",    32'(cpu_di),    32'h11);
    chk("post_vid_valid", 32'(vid_valid), 32'd0);

    // DMA burst: expect DDDDC DDDDC.
    dma_req = 1'b1; dma_we = 1'b0; dma_ad = 16'h0300;
    cpu_cycles = 0; burst_m = 4'd0;
    for (int i = 0; i < 10; i++) begin
      exp_own = (i % 5 == 4) ? 2'd0 : 2'd2;
      #1;
      chk($sformatf("burst_owner_%0d", i), 32'(owner), 32'(exp_own));
      chk($sformatf("burst_ack_%0d", i), 32'(dma_ack), 32'(exp_own == 2'd2));
      if (cpu_rdy) cpu_cycles++;
      prev_dma = (exp_own == 2'd2);
      burst_m  = prev_dma ? burst_m + 4'd1 : 4'd0;
      tick();
      chk($sformatf("burst_cnt_%0d", i), 32'(dut.r_burst_cnt), 32'(burst_m));
      chk($sformatf("burst_valid_%0d", i), 32'(dma_valid), 32'(prev_dma));
    end
    chk("burst_cpu_cycles", 32'(cpu_cycles), 32'd2);

    // Contention: one DMA cycle first so the counter is nonzero, then both request.
    #1;
    chk("pre_cont_ack", 32'(dma_ack), 32'd1);
    tick();
    vid_req = 1'b1; vid_ad = 16'h8100;
    #1;
    chk("cont_vid_ack", 32'(vid_ack), 32'd1);
    chk("cont_dma_ack", 32'(dma_ack), 32'd0);
    tick();
    chk("cont_burst_hold", 32'(dut.r_burst_cnt), 32'd1);
    vid_req = 1'b0;
    #1;
    chk("cont_dma_next", 32'(dma_ack), 32'd1);
    chk("cont_owner",    32'(owner),   32'd2);
    tick();
    chk("cont_burst_inc", 32'(dut.r_burst_cnt), 32'd2);
    dma_req = 1'b0;
    tick();

    // DMA write.
    dma_req = 1'b1; dma_we = 1'b1; dma_ad = 16'h0200; dma_do = 8'h5A;
    #1;
    chk("dw_ack",    32'(dma_ack), 32'd1);
    chk("dw_mem_we", 32'(mem_we),  32'd1);
    chk("dw_mem_ad", 32'(mem_ad),  32'h0200);
    chk("dw_mem_do", 32'(mem_do),  32'h5A);
    tick();
    dma_req = 1'b0; dma_we = 1'b0;
    #1;
    chk("dw_valid",   32'(dma_valid), 32'd0);
    chk("dw_we_drop", 32'(mem_we),    32'd0);
    tick();

    // Reset in the data phase of a DMA read.
    dma_req = 1'b1; dma_ad = 16'h0400;
    #1;
    chk("rd_dma_ack", 32'(dma_ack), 32'd1);
    tick();
    dma_req = 1'b0; RST = 1'b1;
    #1;
    chk("rstmid_valid", 32'(dma_valid), 32'd0);
    tick();
    RST = 1'b0; mem_di = 8'h00;
    #1;
    chk("rstmid_owner",  32'(owner),             32'd0);
    chk("rstmid_burst",  32'(dut.r_burst_cnt),   32'd0);
    chk("rstmid_cpu_di", 32'(cpu_di),            32'h00);
    chk("rstmid_valid2", 32'(dma_valid),         32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
